// File: rtl/dcp_step.sv
// rtl/dcp_step.sv - 'T' command handler: read step count, pulse clk_cpu, print pc
//
// Purpose: child handler of the debug control unit for the single/multi-step
// command. It becomes active when sel_mode equals CMD_CODE. It then:
//   1. reads an optional hex step count through the scanner handshake;
//   2. emits that many clk_cpu_T pulses (CLK_HI high, CLK_LO low);
//   3. prints pc in hex, then prints a newline through the printer handshake;
//   4. holds finish_T until the dispatcher moves sel_mode away.
//
// Ports:
//   clk, rstn               system clock, asynchronous active-low reset
//   sel_mode[7:0]           command currently selected by the dispatcher
//   finish_T                command complete, held while sel_mode == CMD_CODE
//   req_rx_T, type_rx_T     scanner request / type (1 = hex word)
//   ack_rx, flag_rx, din_rx scanner acknowledge, "no number" flag, value
//   req_tx_T, type_tx_T     printer request / type (0 = char, 1 = hex word)
//   ack_tx                  printer acknowledge
//   dout_T[31:0]            data to printer
//   clk_cpu_T               registered CPU clock pulse
//   pc[31:0]                current CPU program counter

module dcp_step #(
  parameter logic [7:0] CMD_CODE = 8'h54,
  parameter int          CLK_HI   = 2,
  parameter int          CLK_LO   = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  sel_mode,
  output logic        finish_T,
  output logic        req_rx_T,
  output logic        type_rx_T,
  input  logic        ack_rx,
  input  logic        flag_rx,
  input  logic [31:0] din_rx,
  output logic        req_tx_T,
  output logic        type_tx_T,
  input  logic        ack_tx,
  output logic [31:0] dout_T,
  output logic        clk_cpu_T,
  input  logic [31:0] pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARG,
    S_CHK,
    S_HI,
    S_LO,
    S_PR_PC,
    S_PR_NL,
    S_DONE
  } state_t;

  localparam logic [15:0] HI_LAST = 16'(CLK_HI - 1);
  localparam logic [15:0] LO_LAST = 16'(CLK_LO - 1);

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [15:0] phase_q;
  logic        finish_q;
  logic        req_rx_q;
  logic        type_rx_q;
  logic        req_tx_q;
  logic        type_tx_q;
  logic [31:0] dout_q;
  logic        clk_cpu_q;

  logic        sel_hit;
  logic [31:0] cnt_dec_d;

  assign sel_hit = (sel_mode == CMD_CODE);
  // Saturating decrement: the step count never wraps below zero.
  assign cnt_dec_d = (cnt_q != 32'd0) ? (cnt_q - 32'd1) : 32'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 32'd0;
      phase_q   <= 16'd0;
      finish_q  <= 1'b0;
      req_rx_q  <= 1'b0;
      type_rx_q <= 1'b0;
      req_tx_q  <= 1'b0;
      type_tx_q <= 1'b0;
      dout_q    <= 32'd0;
      clk_cpu_q <= 1'b0;
    end else if (state_q != S_IDLE && !sel_hit) begin
      // Abort: the dispatcher has moved on, so drop everything at once.
      state_q   <= S_IDLE;
      cnt_q     <= 32'd0;
      phase_q   <= 16'd0;
      finish_q  <= 1'b0;
      req_rx_q  <= 1'b0;
      type_rx_q <= 1'b0;
      req_tx_q  <= 1'b0;
      type_tx_q <= 1'b0;
      dout_q    <= 32'd0;
      clk_cpu_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_hit) begin
            state_q   <= S_ARG;
            req_rx_q  <= 1'b1;
            type_rx_q <= 1'b1;
          end
        end

        S_ARG: begin
          if (req_rx_q && ack_rx) begin
            req_rx_q  <= 1'b0;
            type_rx_q <= 1'b0;
            cnt_q     <= flag_rx ? 32'd1 : din_rx;
            state_q   <= S_CHK;
          end
        end

        S_CHK: begin
          if (cnt_q == 32'd0) begin
            state_q   <= S_PR_PC;
            req_tx_q  <= 1'b1;
            type_tx_q <= 1'b1;
            dout_q    <= pc;
          end else begin
            state_q   <= S_HI;
            phase_q   <= 16'd0;
            clk_cpu_q <= 1'b1;
          end
        end

        S_HI: begin
          if (phase_q == HI_LAST) begin
            state_q   <= S_LO;
            phase_q   <= 16'd0;
            clk_cpu_q <= 1'b0;
          end else begin
            phase_q <= phase_q + 16'd1;
          end
        end

        S_LO: begin
          if (phase_q == LO_LAST) begin
            // The count check happens here on the decremented value.
            // This keeps the step period at CLK_HI + CLK_LO with no idle
            // cycle between pulses.
            cnt_q   <= cnt_dec_d;
            phase_q <= 16'd0;
            if (cnt_dec_d == 32'd0) begin
              state_q   <= S_PR_PC;
              req_tx_q  <= 1'b1;
              type_tx_q <= 1'b1;
              dout_q    <= pc;
            end else begin
              state_q   <= S_HI;
              clk_cpu_q <= 1'b1;
            end
          end else begin
            phase_q <= phase_q + 16'd1;
          end
        end

        S_PR_PC: begin
          if (req_tx_q && ack_tx) begin
            // The newline request is set up now and raised one cycle later.
            // The printer therefore sees req low between the two prints.
            req_tx_q  <= 1'b0;
            type_tx_q <= 1'b0;
            dout_q    <= 32'h0000_000A;
            state_q   <= S_PR_NL;
          end
        end

        S_PR_NL: begin
          if (!req_tx_q) begin
            req_tx_q <= 1'b1;
          end else if (ack_tx) begin
            req_tx_q <= 1'b0;
            finish_q <= 1'b1;
            state_q  <= S_DONE;
          end
        end

        S_DONE: begin
          state_q <= S_DONE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign finish_T  = finish_q;
  assign req_rx_T  = req_rx_q;
  assign type_rx_T = type_rx_q;
  assign req_tx_T  = req_tx_q;
  assign type_tx_T = type_tx_q;
  assign dout_T    = dout_q;
  assign clk_cpu_T = clk_cpu_q;

endmodule
